dpram_be: RTL and testbench

- Single-clock, true dual-port RAM with per-byte write enables, selectable read latency and read-during-write mode.
- Adds a hardware clear sequencer that fills the array with a constant after reset or on request.
- Adds same-address write-collision arbitration with a status pulse.
- Used as shared video/CPU memory where both ports run on the system clock and contents must be deterministic after reset.

---
 rtl/dpram_be.sv | 186 ++++++++++++++++++
 tb/tb_dpram_be.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be.sv
// dpram_be: single-clock true dual-port RAM with per-byte write enables.
//   - Clear sequencer fills every word with clear_value_g after reset and
//     whenever `clear` is pulsed while idle; both ports are blocked while busy.
//   - Same-address writes on both ports: port A wins on overlapping lanes.
//     `collision` pulses the cycle after an overlap.
//   - Every access (read or write) issues a read. q/valid appear after
//     rd_latency_g edges (1 or 2). q holds between completed reads.
//   - rdw_new_g selects old (0) or fully merged new (1) data on read-during-write.
// Ports:
//   clock, reset_n            system clock, async active-low reset
//   clear, busy, collision    clear request, sequencer active, write collision pulse
//   ram_cs/wren_a/be_a/address_a/data_a -> q_a/valid_a        port A
//   ram_cs_b/wren_b/be_b/address_b/data_b -> q_b/valid_b      port B

// One byte lane of storage for both ports. we_b must already be masked
// where port A wins, so lane-local write order does not matter.
module dpram_be_lane #(
  parameter int AW      = 10,
  parameter int BW      = 8,
  parameter int RDW_NEW = 0
) (
  input  logic          clock,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [BW-1:0] wd_a,
  input  logic [BW-1:0] wd_b,
  output logic [BW-1:0] rd_a,
  output logic [BW-1:0] rd_b
);
  logic [BW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we_a) mem[addr_a] <= wd_a;
    if (we_b) mem[addr_b] <= wd_b;
  end

  generate
    if (RDW_NEW != 0) begin : g_new
      // Value the lane will hold after this edge's writes.
      always_comb begin
        rd_a = mem[addr_a];
        if (we_b && addr_b == addr_a) rd_a = wd_b;
        if (we_a)                     rd_a = wd_a;
        rd_b = mem[addr_b];
        if (we_b)                     rd_b = wd_b;
        if (we_a && addr_a == addr_b) rd_b = wd_a;
      end
    end else begin : g_old
      assign rd_a = mem[addr_a];
      assign rd_b = mem[addr_b];
    end
  endgenerate
endmodule

module dpram_be #(
  parameter int data_width_g = 16,
  parameter int addr_width_g = 10,
  parameter int byte_width_g = 8,
  parameter int rd_latency_g = 1,
  parameter int rdw_new_g    = 0,
  parameter logic [data_width_g-1:0] clear_value_g = '0,
  localparam int NB = data_width_g / byte_width_g
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  output logic                    busy,
  output logic                    collision,
  input  logic                    ram_cs,
  input  logic                    wren_a,
  input  logic [NB-1:0]           be_a,
  input  logic [addr_width_g-1:0] address_a,
  input  logic [data_width_g-1:0] data_a,
  output logic [data_width_g-1:0] q_a,
  output logic                    valid_a,
  input  logic                    ram_cs_b,
  input  logic                    wren_b,
  input  logic [NB-1:0]           be_b,
  input  logic [addr_width_g-1:0] address_b,
  input  logic [data_width_g-1:0] data_b,
  output logic [data_width_g-1:0] q_b,
  output logic                    valid_b
);
  localparam int AW = addr_width_g;
  localparam int DW = data_width_g;
  localparam int BW = byte_width_g;
  localparam int L  = rd_latency_g;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] cnt;

  // Reset lands in CLEAR so the fill starts on the first edge after release.
  // busy mirrors state, so it is high for exactly 2**AW cycles per clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (clear) begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (&cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic          acc_a, acc_b, wr_a, wr_b, same;
  logic [NB-1:0] we_a, we_b;
  logic [AW-1:0] ma;
  logic [DW-1:0] wd_a, rd_a, rd_b;

  assign acc_a = ram_cs   & ~busy;
  assign acc_b = ram_cs_b & ~busy;
  assign wr_a  = acc_a & wren_a;
  assign wr_b  = acc_b & wren_b;
  assign same  = address_a == address_b;

  // While busy, port A's write path carries the clear sequencer.
  assign ma   = busy ? cnt : address_a;
  assign wd_a = busy ? clear_value_g : data_a;

  for (genvar i = 0; i < NB; i++) begin : g_we
    assign we_a[i] = busy | (wr_a & be_a[i]);
    assign we_b[i] = wr_b & be_b[i] & ~(same & wr_a & be_a[i]);
  end

  dpram_be_lane #(.AW(AW), .BW(BW), .RDW_NEW(rdw_new_g)) u_lane [NB-1:0] (
    .clock (clock),
    .we_a  (we_a),
    .we_b  (we_b),
    .addr_a(ma),
    .addr_b(address_b),
    .wd_a  (wd_a),
    .wd_b  (data_b),
    .rd_a  (rd_a),
    .rd_b  (rd_b)
  );

  // Read pipelines, index 0 = port A, 1 = port B. Data stages load only
  // alongside their valid bit, so q holds when no read completes.
  logic [1:0]                vld_in;
  logic [1:0][DW-1:0]        dat_in;
  logic [1:0][L:1]           vld_pipe;
  logic [1:0][L:1][DW-1:0]   dat_pipe;

  assign vld_in = {acc_b, acc_a};
  assign dat_in = {rd_b, rd_a};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      dat_pipe  <= '0;
      collision <= 1'b0;
    end else begin
      collision <= wr_a & wr_b & same & (|(be_a & be_b));
      for (int p = 0; p < 2; p++) begin
        vld_pipe[p][1] <= vld_in[p];
        if (vld_in[p]) dat_pipe[p][1] <= dat_in[p];
        for (int s = 2; s <= L; s++) begin
          vld_pipe[p][s] <= vld_pipe[p][s-1];
          if (vld_pipe[p][s-1]) dat_pipe[p][s] <= dat_pipe[p][s-1];
        end
      end
    end
  end

  assign q_a     = dat_pipe[0][L];
  assign valid_a = vld_pipe[0][L];
  assign q_b     = dat_pipe[1][L];
  assign valid_b = vld_pipe[1][L];
endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be. Two instances share the same stimulus:
//   u1: latency 1, old data on read-during-write
//   u2: latency 2, new (merged) data on read-during-write
// Stimulus pushes hand-computed expected words per port/instance; a
// negedge monitor pops and compares whenever valid is high, also checking
// the observed latency.
module tb_dpram_be;
  logic        clock = 0, reset_n = 0, clear = 0;
  logic        ram_cs = 0, wren_a = 0, ram_cs_b = 0, wren_b = 0;
  logic [1:0]  be_a = 0, be_b = 0;
  logic [3:0]  address_a = 0, address_b = 0;
  logic [15:0] data_a = 0, data_b = 0;
  logic        busy1, coll1, va1, vb1, busy2, coll2, va2, vb2;
  logic [15:0] qa1, qb1, qa2, qb2;

  dpram_be #(.data_width_g(16), .addr_width_g(4), .byte_width_g(8),
             .rd_latency_g(1), .rdw_new_g(0)) u1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy1), .collision(coll1),
    .ram_cs(ram_cs), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
    .data_a(data_a), .q_a(qa1), .valid_a(va1),
    .ram_cs_b(ram_cs_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
    .data_b(data_b), .q_b(qb1), .valid_b(vb1));

  dpram_be #(.data_width_g(16), .addr_width_g(4), .byte_width_g(8),
             .rd_latency_g(2), .rdw_new_g(1)) u2 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy2), .collision(coll2),
    .ram_cs(ram_cs), .wren_a(wren_a), .be_a(be_a), .address_a(address_a),
    .data_a(data_a), .q_a(qa2), .valid_a(va2),
    .ram_cs_b(ram_cs_b), .wren_b(wren_b), .be_b(be_b), .address_b(address_b),
    .data_b(data_b), .q_b(qb2), .valid_b(vb2));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [15:0] d; int c; } ent_t;
  ent_t sb0[$], sb1[$], sb2[$], sb3[$];
  int total = 0, bad = 0;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input int s, input logic [15:0] act, input int lat);
    ent_t  e;
    int    n;
    string nm;
    case (s)
      0: begin nm = "u1_qa"; n = sb0.size(); end
      1: begin nm = "u1_qb"; n = sb1.size(); end
      2: begin nm = "u2_qa"; n = sb2.size(); end
      default: begin nm = "u2_qb"; n = sb3.size(); end
    endcase
    if (n == 0) begin
      total++; bad++;
      $display("FAIL %s: unexpected valid with q=%h, expected no read", nm, act);
      return;
    end
    case (s)
      0: e = sb0.pop_front();
      1: e = sb1.pop_front();
      2: e = sb2.pop_front();
      default: e = sb3.pop_front();
    endcase
    chk(nm, act, e.d);
    chk({nm, "_lat"}, cyc - e.c, lat);
  endtask

  always @(negedge clock) begin
    if (va1) pop_chk(0, qa1, 1);
    if (vb1) pop_chk(1, qb1, 1);
    if (va2) pop_chk(2, qa2, 2);
    if (vb2) pop_chk(3, qb2, 2);
  end

  // One cycle on both ports. ea1/eb1: expected q for u1 (old), ea2/eb2 for u2 (new).
  task automatic acc(input logic ca, input logic wa, input logic [1:0] ba, input logic [3:0] aa,
                     input logic [15:0] da, input logic [15:0] ea1, input logic [15:0] ea2,
                     input logic cb, input logic wb, input logic [1:0] bb, input logic [3:0] ab,
                     input logic [15:0] db, input logic [15:0] eb1, input logic [15:0] eb2,
                     input logic ec);
    ent_t e;
    ram_cs = ca; wren_a = wa; be_a = ba; address_a = aa; data_a = da;
    ram_cs_b = cb; wren_b = wb; be_b = bb; address_b = ab; data_b = db;
    e.c = cyc;
    if (ca) begin e.d = ea1; sb0.push_back(e); e.d = ea2; sb2.push_back(e); end
    if (cb) begin e.d = eb1; sb1.push_back(e); e.d = eb2; sb3.push_back(e); end
    @(posedge clock); #1;
    chk("u1_collision", coll1, ec);
    chk("u2_collision", coll2, ec);
    ram_cs = 0; wren_a = 0; ram_cs_b = 0; wren_b = 0;
  endtask

  task automatic rda(input logic [3:0] a, input logic [15:0] e1, input logic [15:0] e2);
    acc(1, 0, 2'b00, a, 16'h0, e1, e2, 0, 0, 2'b00, 4'h0, 16'h0, 16'h0, 16'h0, 0);
  endtask

  task automatic rdb(input logic [3:0] a, input logic [15:0] e1, input logic [15:0] e2);
    acc(0, 0, 2'b00, 4'h0, 16'h0, 16'h0, 16'h0, 1, 0, 2'b00, a, 16'h0, e1, e2, 0);
  endtask

  task automatic wra(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be,
                     input logic [15:0] eold, input logic [15:0] enew);
    acc(1, 1, be, a, d, eold, enew, 0, 0, 2'b00, 4'h0, 16'h0, 16'h0, 16'h0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (busy1 && n < 100);
  endtask

  initial begin
    int n;
    logic [15:0] tbl [4];
    tbl[0] = 16'h0A0A; tbl[1] = 16'hB1B1; tbl[2] = 16'h2C2C; tbl[3] = 16'h3D3D;

    // Reset state
    repeat (3) @(posedge clock); #1;
    chk("rst_busy1", busy1, 1); chk("rst_busy2", busy2, 1);
    chk("rst_va1", va1, 0); chk("rst_vb1", vb1, 0); chk("rst_va2", va2, 0);
    chk("rst_qa1", qa1, 0); chk("rst_qb2", qb2, 0); chk("rst_coll1", coll1, 0);
    @(negedge clock) reset_n = 1;
    count_busy(n);
    chk("busy_len_reset", n, 16);
    chk("busy2_after_reset", busy2, 0);

    // Post-reset contents, both ports, back-to-back
    for (int i = 0; i < 16; i++)
      acc(1, 0, 2'b00, 4'(i), 16'h0, 16'h0, 16'h0,
          1, 0, 2'b00, 4'(15 - i), 16'h0, 16'h0, 16'h0, 0);

    // Byte enables
    wra(4'd3, 16'hBEEF, 2'b11, 16'h0000, 16'hBEEF);
    wra(4'd3, 16'h1234, 2'b01, 16'hBEEF, 16'hBE34);
    rda(4'd3, 16'hBE34, 16'hBE34);
    idle(3);
    chk("hold_qa1", qa1, 16'hBE34); chk("hold_qa2", qa2, 16'hBE34);
    chk("hold_va1", va1, 0); chk("hold_va2", va2, 0);

    // Collision: full overlap, A wins
    acc(1, 1, 2'b11, 4'd5, 16'hAAAA, 16'h0000, 16'hAAAA,
        1, 1, 2'b11, 4'd5, 16'h5555, 16'h0000, 16'hAAAA, 1);
    rda(4'd5, 16'hAAAA, 16'hAAAA);
    // Same address, disjoint lanes: both land, no pulse
    acc(1, 1, 2'b01, 4'd5, 16'hAAAA, 16'hAAAA, 16'h55AA,
        1, 1, 2'b10, 4'd5, 16'h5555, 16'hAAAA, 16'h55AA, 0);
    rdb(4'd5, 16'h55AA, 16'h55AA);

    // Read-during-write, cross-port both directions
    wra(4'd7, 16'h1111, 2'b11, 16'h0000, 16'h1111);
    acc(1, 1, 2'b11, 4'd7, 16'h2222, 16'h1111, 16'h2222,
        1, 0, 2'b00, 4'd7, 16'h0000, 16'h1111, 16'h2222, 0);
    acc(1, 0, 2'b00, 4'd7, 16'h0000, 16'h2222, 16'h22CC,
        1, 1, 2'b01, 4'd7, 16'h00CC, 16'h2222, 16'h22CC, 0);
    rdb(4'd7, 16'h22CC, 16'h22CC);

    // Independent addresses
    acc(1, 1, 2'b11, 4'd0, 16'h0A0A, 16'h0000, 16'h0A0A,
        1, 1, 2'b11, 4'd1, 16'hB1B1, 16'h0000, 16'hB1B1, 0);
    acc(1, 1, 2'b11, 4'd2, 16'h2C2C, 16'h0000, 16'h2C2C,
        1, 1, 2'b11, 4'd3, 16'h3D3D, 16'hBE34, 16'h3D3D, 0);
    // be all-zero is a read; cs low with wren high does nothing
    wra(4'd0, 16'hFFFF, 2'b00, 16'h0A0A, 16'h0A0A);
    ram_cs = 0; wren_a = 1; be_a = 2'b11; address_a = 4'd0; data_a = 16'hFFFF;
    @(posedge clock); #1;
    wren_a = 0;
    // Back-to-back reads, data in order on both latencies
    for (int i = 0; i < 4; i++)
      acc(1, 0, 2'b00, 4'(i), 16'h0, tbl[i], tbl[i],
          1, 0, 2'b00, 4'(3 - i), 16'h0, tbl[3 - i], tbl[3 - i], 0);
    idle(3);

    // Clear request from idle
    clear = 1;
    @(posedge clock); #1;
    clear = 0;
    chk("clear_busy_set", busy1, 1);
    count_busy(n);
    chk("busy_len_clear", n, 16);
    rda(4'd7, 16'h0000, 16'h0000);
    rdb(4'd3, 16'h0000, 16'h0000);

    // Fill, then clear interrupted by reset, with writes and clear while busy
    for (int i = 0; i < 16; i++) wra(4'(i), 16'hFFFF, 2'b11, 16'h0000, 16'hFFFF);
    rda(4'd9, 16'hFFFF, 16'hFFFF);
    idle(2);
    clear = 1;
    @(posedge clock); #1;
    clear = 0;
    idle(8);
    reset_n = 0;
    ram_cs = 1; wren_a = 1; be_a = 2'b11; address_a = 4'd0; data_a = 16'hDEAD;
    ram_cs_b = 1; wren_b = 1; be_b = 2'b11; address_b = 4'd15; data_b = 16'hBEAD;
    idle(2);
    chk("midrst_busy", busy1, 1); chk("midrst_qa1", qa1, 0); chk("midrst_qa2", qa2, 0);
    @(negedge clock) reset_n = 1;
    n = 0;
    forever begin
      @(posedge clock); #1;
      n++;
      if (!busy1 || n >= 100) break;
      address_a = 4'(n);
      address_b = 4'(15 - n);
      clear = (n == 5);
    end
    ram_cs = 0; wren_a = 0; ram_cs_b = 0; wren_b = 0; clear = 0;
    chk("busy_len_midrst", n, 16);
    for (int i = 0; i < 16; i++)
      acc(1, 0, 2'b00, 4'(i), 16'h0, 16'h0, 16'h0,
          1, 0, 2'b00, 4'(15 - i), 16'h0, 16'h0, 16'h0, 0);

    idle(4);
    chk("drain_u1a", sb0.size(), 0); chk("drain_u1b", sb1.size(), 0);
    chk("drain_u2a", sb2.size(), 0); chk("drain_u2b", sb3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
